demux1x2_25b_stream: RTL and testbench
======================================

DEMUX1X2_25B_STREAM -- requirements
Module: demux1x2_25b_stream

Interface
REQ-001 Parameter WIDTH, default 25, data word width in bits; the block SHALL be correct for any WIDTH >= 1.
REQ-002 Parameter DEPTH, default 2, entries per output queue; the block SHALL support DEPTH = 2 and DEPTH = 4.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  source presents a word.
REQ-006 in_ready  output  1  block accepts the presented word this cycle.
REQ-007 in_data  input  WIDTH  word to be steered.
REQ-008 in_sel  input  1  destination select: 0 selects port 0, 1 selects port 1.
REQ-009 out0_valid / out1_valid  output  1 each  port holds a word.
REQ-010 out0_ready / out1_ready  input  1 each  sink consumes the word this cycle.
REQ-011 out0_data / out1_data  output  WIDTH each  head word of the port queue.
REQ-012 cnt0 / cnt1  output  16 each  words delivered on port 0 / port 1.

Function
REQ-013 A transfer SHALL occur on the input when in_valid and in_ready are both 1 at a rising edge.
REQ-014 A delivery SHALL occur on port k when outk_valid and outk_ready are both 1 at a rising edge.
REQ-015 Each port SHALL own an independent FIFO queue of DEPTH entries with a wrapping write pointer, a wrapping read pointer and an occupancy count from 0 to DEPTH.
REQ-016 in_ready SHALL equal 1 when the queue selected by the current in_sel has occupancy < DEPTH, or when that queue is full and is delivering this cycle (full-queue pass-through); otherwise it SHALL be 0.
REQ-017 in_ready SHALL depend only on in_sel, the selected queue's occupancy and the selected port's outk_ready; it SHALL NOT depend on in_valid.
REQ-018 An accepted word SHALL be written only to the queue named by in_sel; the other queue SHALL be unchanged.
REQ-019 Latency: a word accepted into an empty queue at edge N SHALL appear on outk_data with outk_valid = 1 after edge N; there is no same-cycle combinational bypass.
REQ-020 outk_valid SHALL be 1 exactly when queue k occupancy > 0; outk_data SHALL be the oldest unread word of queue k.
REQ-021 Simultaneous write and delivery on the same queue SHALL leave its occupancy unchanged and SHALL advance both pointers.
REQ-022 Words SHALL leave each port in the order they were accepted for that port; ordering between ports is unconstrained.
REQ-023 Queues SHALL never overflow, underflow or drop a word; outk_data SHALL not change while outk_valid = 1 and outk_ready = 0.
REQ-024 cntk SHALL increment by 1 on every delivery on port k and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 Changing in_sel while in_valid = 1 and in_ready = 0 is legal; in_ready SHALL re-evaluate against the newly selected queue in the same cycle.

Reset
REQ-026 While reset_n = 0, both occupancies, all pointers and cnt0/cnt1 SHALL be 0; out0_valid and out1_valid SHALL be 0; out0_data and out1_data SHALL be 0.
REQ-027 Assertion of reset_n mid-operation SHALL discard all queued words immediately, without waiting for a clock edge.
REQ-028 in_ready SHALL be 0 while reset_n = 0.
REQ-029 The first transfer SHALL be possible at the first rising edge after reset_n is deasserted.

Verification
REQ-030 Basic steering: reset, then send 25'h1ABCDEF with in_sel = 0 and 25'h0000001 with in_sel = 1 -> out0_data = 25'h1ABCDEF and out1_data = 25'h0000001, each valid one cycle after its transfer; cnt0 = cnt1 = 1 after both ports are drained.
REQ-031 Full / backpressure: DEPTH = 2, out0_ready = 0, send three words to port 0 -> in_ready = 0 after two transfers; set in_sel = 1 -> in_ready = 1 in the same cycle, and the third word is accepted to port 1.
REQ-032 Pass-through at full: DEPTH = 2, port 0 full, out0_ready = 1 and in_valid = 1 -> in_ready = 1, occupancy stays 2, and the words are delivered in order A, B, C.
REQ-033 Counter wrap: force 65,536 deliveries on port 1 -> cnt1 returns to 16'h0000 while cnt0 is unchanged.
REQ-034 Reset mid-operation: with both queues holding words, pulse reset_n low between clock edges -> out0_valid and out1_valid fall to 0 immediately, and data and counters read 0.
REQ-035 Random soak: 10,000 cycles with random in_valid, in_sel and outk_ready -> a scoreboard sees per-port order preserved, no loss or duplication, and cntk equal to the scoreboard delivery counts.

Source files
------------

// File: rtl/demux1x2_25b_stream.sv
// demux1x2_25b_stream: steers one input stream into two independent FIFO
// queues. Each output port owns a DEPTH-entry queue and a 16-bit delivery
// counter. A full queue still accepts a word in the cycle it delivers.

// One output queue with its delivery counter; instantiated once per port.
module demux1x2_25b_stream_q #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic [15:0]      o_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               r_wp;
    logic [AW-1:0]               r_rp;
    logic [OW-1:0]               r_occ;
    logic [15:0]                 r_cnt;
    logic [AW-1:0]               w_wp_nxt;
    logic [AW-1:0]               w_rp_nxt;

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    assign w_wp_nxt = (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    assign w_rp_nxt = (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

    // Storage, pointers, occupancy and delivery counter; storage is cleared
    // on reset so the head word reads 0 while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= w_wp_nxt;
            end
            if (i_rd) begin
                r_rp  <= w_rp_nxt;
                r_cnt <= r_cnt + 16'd1;
            end
            case ({i_wr, i_rd})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_valid = (r_occ != '0);
    assign o_full  = (r_occ == OW'(DEPTH));
    assign o_data  = r_mem[r_rp];
    assign o_cnt   = r_cnt;
endmodule

// Top: selects the destination queue and forms the input handshake.
module demux1x2_25b_stream #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);
    logic [1:0]             w_ready;
    logic [1:0]             w_valid;
    logic [1:0]             w_full;
    logic [1:0]             w_wr;
    logic [1:0]             w_rd;
    logic [1:0][WIDTH-1:0]  w_data;
    logic [1:0][15:0]       w_cnt;
    logic                   w_accept;

    assign w_ready = {out1_ready, out0_ready};

    // A full queue is necessarily valid, so its ready alone means it frees a
    // slot this cycle; in_valid is deliberately not part of this term.
    assign in_ready = reset_n & (~w_full[in_sel] | w_ready[in_sel]);
    assign w_accept = in_valid & in_ready;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_port
            assign w_wr[g] = w_accept & (in_sel == 1'(g));
            assign w_rd[g] = w_valid[g] & w_ready[g];

            demux1x2_25b_stream_q #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_q (
                .clk     (clk),
                .reset_n (reset_n),
                .i_wr    (w_wr[g]),
                .i_wdata (in_data),
                .i_rd    (w_rd[g]),
                .o_valid (w_valid[g]),
                .o_full  (w_full[g]),
                .o_data  (w_data[g]),
                .o_cnt   (w_cnt[g])
            );
        end
    endgenerate

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];
endmodule

// File: tb/tb_demux1x2_25b_stream.sv
// Scoreboard bench for demux1x2_25b_stream: stimulus pushes accepted words
// into per-port queues; a monitor pops and compares on each delivery.
module tb_demux1x2_25b_stream;
    localparam int WIDTH = 25;
    localparam int DEPTH = 2;
    typedef logic [WIDTH-1:0] word_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 1'b0;
    logic             out0_valid, out1_valid;
    logic             out0_ready = 1'b0, out1_ready = 1'b0;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [15:0]      cnt0, cnt1;

    int vectors = 0;
    int errors  = 0;

    word_t       sbq[2][$];
    int unsigned exp_cnt[2];
    int          occ_snap[2];

    demux1x2_25b_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: 3 time units after each negedge, before stimulus records new
    // transfers, so the model queues reflect exactly what the DUT holds.
    initial begin
        logic        v, r;
        word_t       d;
        logic [15:0] c;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n) begin
                for (int k = 0; k < 2; k++) begin
                    v = (k == 0) ? out0_valid : out1_valid;
                    r = (k == 0) ? out0_ready : out1_ready;
                    d = (k == 0) ? out0_data  : out1_data;
                    c = (k == 0) ? cnt0       : cnt1;
                    check($sformatf("out%0d_valid", k), 32'(v), 32'(sbq[k].size() > 0));
                    check($sformatf("cnt%0d", k), 32'(c), 32'(16'(exp_cnt[k])));
                    occ_snap[k] = sbq[k].size();
                    if (sbq[k].size() > 0)
                        check($sformatf("out%0d_data", k), 32'(d), 32'(sbq[k][0]));
                    if (v && r && sbq[k].size() > 0) begin
                        void'(sbq[k].pop_front());
                        exp_cnt[k]++;
                    end
                end
            end
        end
    end

    // One cycle of stimulus; records the transfer the DUT will take.
    task automatic drive(input logic v, input logic sel, input word_t d,
                         input logic r0, input logic r1);
        logic rdy_sel;
        logic exp_rdy;
        @(negedge clk);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #4;
        rdy_sel = sel ? r1 : r0;
        exp_rdy = (occ_snap[sel] < DEPTH) || rdy_sel;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (v && in_ready) sbq[sel].push_back(d);
    endtask

    // Reset pulse strictly between clock edges; checks the reset state.
    task automatic reset_pulse();
        @(negedge clk);
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sbq[k].delete();
            exp_cnt[k]  = 0;
            occ_snap[k] = 0;
        end
        #1;
        check("rst out0_valid", 32'(out0_valid), 32'd0);
        check("rst out1_valid", 32'(out1_valid), 32'd0);
        check("rst out0_data", 32'(out0_data), 32'd0);
        check("rst out1_data", 32'(out1_data), 32'd0);
        check("rst cnt0", 32'(cnt0), 32'd0);
        check("rst cnt1", 32'(cnt1), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        word_t wa, wb, wc;
        // Basic steering
        reset_pulse();
        drive(1'b1, 1'b0, 25'h1ABCDEF, 1'b0, 1'b0);
        check("latency out0_valid", 32'(out0_valid), 32'd0);
        drive(1'b1, 1'b1, 25'h0000001, 1'b0, 1'b0);
        check("basic out0_data", 32'(out0_data), 32'h1ABCDEF);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("basic out1_data", 32'(out1_data), 32'h0000001);
        check("basic out1_valid", 32'(out1_valid), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("basic cnt0", 32'(cnt0), 32'd1);
        check("basic cnt1", 32'(cnt1), 32'd1);

        // Full / backpressure and re-selection
        reset_pulse();
        wa = 25'h0AAAAAA; wb = 25'h1555555; wc = 25'h0123456;
        drive(1'b1, 1'b0, wa, 1'b0, 1'b0);
        drive(1'b1, 1'b0, wb, 1'b0, 1'b0);
        drive(1'b1, 1'b0, wc, 1'b0, 1'b0);
        check("full in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 1'b1, wc, 1'b0, 1'b0);
        check("resel in_ready", 32'(in_ready), 32'd1);

        // Pass-through at full: port 0 holds A,B; C enters while A leaves
        drive(1'b1, 1'b0, wc, 1'b1, 1'b1);
        check("pass in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pass head B", 32'(out0_data), 32'(wb));
        check("pass still full", 32'(in_ready), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pass head C", 32'(out0_data), 32'(wc));
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Counter wrap on port 1
        reset_pulse();
        for (int i = 0; i < 65537; i++)
            drive(1'b1, 1'b1, word_t'($urandom()), 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("wrap cnt1", 32'(cnt1), 32'd0);
        check("wrap cnt0", 32'(cnt0), 32'd0);

        // Reset mid-operation with both queues occupied
        drive(1'b1, 1'b0, 25'h1F0F0F0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pre-rst out0_valid", 32'(out0_valid), 32'd1);
        check("pre-rst out1_valid", 32'(out1_valid), 32'd1);
        reset_pulse();

        // Random soak
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom()), 1'($urandom()), word_t'($urandom()),
                  1'($urandom()), 1'($urandom()));
        for (int i = 0; i < 2 * DEPTH + 1; i++)
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("drain out0_valid", 32'(out0_valid), 32'd0);
        check("drain out1_valid", 32'(out1_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
